// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between NREQ requesters over a
// valid/ack handshake; every output is registered.
module adder_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned W    = 25
) (
  input  logic              CLK,
  input  logic              RSTK,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_datain1,
  input  logic [NREQ*W-1:0] req_datain2,
  output logic [NREQ-1:0]   req_ack,
  output logic [W-1:0]      req_dataout,
  output logic              req_carryout,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      Adder_datain1,
  output logic [W-1:0]      Adder_datain2,
  output logic              Adder_valid,
  input  logic [W-1:0]      Adder_dataout,
  input  logic              Adder_carryout,
  input  logic              Adder_ack
);

  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  arb_state_e       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  // First asserted request after the last served index, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!pick_valid && req_valid[(int'(rr_ptr) + k) % int'(NREQ)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(rr_ptr) + k) % int'(NREQ));
      end
    end
  end

  // State, pointer and all outputs in one registered process.
  always_ff @(posedge CLK) begin
    if (!RSTK) begin
      state         <= ARB_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      req_ack       <= '0;
      req_dataout   <= '0;
      req_carryout  <= 1'b0;
      grant         <= '0;
      busy          <= 1'b0;
      Adder_valid   <= 1'b0;
      Adder_datain1 <= '0;
      Adder_datain2 <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            Adder_datain1 <= req_datain1[int'(pick_idx)*int'(W) +: W];
            Adder_datain2 <= req_datain2[int'(pick_idx)*int'(W) +: W];
            Adder_valid   <= 1'b1;
            grant         <= NREQ'(1) << pick_idx;
            owner         <= pick_idx;
            busy          <= 1'b1;
            state         <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (Adder_ack) begin
            req_dataout  <= Adder_dataout;
            req_carryout <= Adder_carryout;
            req_ack      <= grant;
            Adder_valid  <= 1'b0;
            state        <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          // Hold the ack until both the owner and the adder have let go.
          if (!req_valid[owner] && !Adder_ack) begin
            req_ack <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            rr_ptr  <= owner;
            state   <= ARB_IDLE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed scenarios plus randomized
// traffic against a behavioural adder and round-robin reference model.
module tb_adder_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned W    = 25;

  logic              CLK = 1'b0;
  logic              RSTK;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_datain1;
  logic [NREQ*W-1:0] req_datain2;
  logic [NREQ-1:0]   req_ack;
  logic [W-1:0]      req_dataout;
  logic              req_carryout;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [W-1:0]      Adder_datain1;
  logic [W-1:0]      Adder_datain2;
  logic              Adder_valid;
  logic [W-1:0]      a_sum = '0;
  logic              a_cy  = 1'b0;
  logic              a_ack = 1'b0;

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .CLK(CLK), .RSTK(RSTK),
    .req_valid(req_valid), .req_datain1(req_datain1), .req_datain2(req_datain2),
    .req_ack(req_ack), .req_dataout(req_dataout), .req_carryout(req_carryout),
    .grant(grant), .busy(busy),
    .Adder_datain1(Adder_datain1), .Adder_datain2(Adder_datain2),
    .Adder_valid(Adder_valid), .Adder_dataout(a_sum),
    .Adder_carryout(a_cy), .Adder_ack(a_ack)
  );

  always #5 CLK = ~CLK;

  // Requester-side stimulus, one slot per requester.
  logic         rv  [NREQ];
  logic [W-1:0] op1 [NREQ];
  logic [W-1:0] op2 [NREQ];

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_valid[i]           = rv[i];
      req_datain1[i*W +: W]  = op1[i];
      req_datain2[i*W +: W]  = op2[i];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  // Winner = nearest pending index after the last served one, cyclically.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (v[(last + k) % int'(NREQ)]) return (last + k) % int'(NREQ);
    end
    return 0;
  endfunction

  // Behavioural adder: fixed or random ack latency and release hold.
  int cfg_lat  = 2;
  int cfg_hold = 0;
  bit cfg_rand = 1'b0;
  int a_cnt    = 0;

  always @(posedge CLK) begin
    if (!RSTK) begin
      a_ack <= 1'b0;
      a_cnt <= 0;
    end else if (Adder_valid && !a_ack) begin
      if (cfg_rand ? ($urandom_range(0, 2) == 0) : (a_cnt + 1 >= cfg_lat)) begin
        a_ack         <= 1'b1;
        {a_cy, a_sum} <= {1'b0, Adder_datain1} + {1'b0, Adder_datain2};
        a_cnt         <= 0;
      end else begin
        a_cnt <= a_cnt + 1;
      end
    end else if (!Adder_valid && a_ack) begin
      if (cfg_rand ? ($urandom_range(0, 1) == 0) : (a_cnt >= cfg_hold)) begin
        a_ack <= 1'b0;
        a_cnt <= 0;
      end else begin
        a_cnt <= a_cnt + 1;
      end
    end
  end

  // Scoreboard of expected {carry,sum} tagged with the issuing requester.
  int          exp_id  [$];
  logic [W:0]  exp_val [$];
  logic [NREQ-1:0] grant_log [$];

  task automatic run_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    exp_id.push_back(id);
    exp_val.push_back({1'b0, a} + {1'b0, b});
    op1[id] = a;
    op2[id] = b;
    rv[id]  = 1'b1;
    n = 0;
    while (!req_ack[id] && n < 300) begin tick(); n++; end
    if (!req_ack[id]) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack, required ack within 300 cycles", id);
    end
    rv[id] = 1'b0;
    n = 0;
    while (req_ack[id] && n < 300) begin tick(); n++; end
    if (req_ack[id]) begin
      n_tests++; n_fail++;
      $display("FAIL release_timeout: requester %0d ack stuck high, required low", id);
    end
  endtask

  // Monitor: compares grants, operands and results against the model.
  logic            prev_rstk = 1'b0;
  logic            prev_busy = 1'b0;
  logic            prev_aack = 1'b0;
  logic [NREQ-1:0] prev_rv   = '0;
  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] prev_ack  = '0;
  logic [W-1:0]    prev_op1 [NREQ];
  logic [W-1:0]    prev_op2 [NREQ];
  int              last_served = 0;
  int              cur_owner   = 0;
  int              m_e;
  int              m_j;

  always @(negedge CLK) begin
    if (prev_rstk) begin
      if (!prev_busy) begin
        if (prev_rv == '0) begin
          chk("idle_grant", 64'(grant), 64'(0));
        end else begin
          m_e = rr_pick(prev_rv, last_served);
          chk("grant", 64'(grant), 64'(onehot(m_e)));
          chk("grant_busy", 64'(busy), 64'(1));
          chk("grant_adder_valid", 64'(Adder_valid), 64'(1));
          chk("adder_op1", 64'(Adder_datain1), 64'(prev_op1[m_e]));
          chk("adder_op2", 64'(Adder_datain2), 64'(prev_op2[m_e]));
          cur_owner = m_e;
          grant_log.push_back(grant);
        end
      end
      if (prev_grant != '0 && grant == '0) begin
        chk("release_cond", 64'({prev_rv[cur_owner], prev_aack}), 64'(0));
        chk("release_busy", 64'(busy), 64'(0));
        chk("release_ack", 64'(req_ack), 64'(0));
        last_served = cur_owner;
      end
      if (prev_ack == '0 && req_ack != '0) begin
        chk("ack_owner", 64'(req_ack), 64'(onehot(cur_owner)));
        chk("ack_adder_valid", 64'(Adder_valid), 64'(0));
        chk("ack_after_adder_ack", 64'(prev_aack), 64'(1));
        m_j = -1;
        foreach (exp_id[q]) if (m_j < 0 && exp_id[q] == cur_owner) m_j = q;
        if (m_j < 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: requester %0d acked, required no ack (nothing pending)", cur_owner);
        end else begin
          chk("result", 64'({req_carryout, req_dataout}), 64'(exp_val[m_j]));
          exp_id.delete(m_j);
          exp_val.delete(m_j);
        end
      end
    end else begin
      last_served = 0;
    end
    prev_rstk  = RSTK;
    prev_busy  = busy;
    prev_aack  = a_ack;
    prev_rv    = req_valid;
    prev_grant = grant;
    prev_ack   = req_ack;
    prev_op1   = op1;
    prev_op2   = op2;
  end

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic rand_req(input int id);
    repeat (15) begin
      repeat ($urandom_range(0, 3)) tick();
      run_req(id, rnd_op(), rnd_op());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  initial begin
    int n, k, s;
    RSTK = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin rv[i] = 1'b0; op1[i] = '0; op2[i] = '0; end

    // Reset with random requester activity.
    repeat (3) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        rv[i] = 1'($urandom); op1[i] = rnd_op(); op2[i] = rnd_op();
      end
      tick();
    end
    chk("rst_req_ack", 64'(req_ack), 64'(0));
    chk("rst_dataout", 64'(req_dataout), 64'(0));
    chk("rst_carry", 64'(req_carryout), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_adder_valid", 64'(Adder_valid), 64'(0));
    chk("rst_adder_op1", 64'(Adder_datain1), 64'(0));
    chk("rst_adder_op2", 64'(Adder_datain2), 64'(0));
    for (int i = 0; i < int'(NREQ); i++) rv[i] = 1'b0;
    RSTK = 1'b1;
    tick();

    // Single request, adder acks after 2 cycles.
    fork
      run_req(0, 25'h0000003, 25'h0000005);
      begin
        n = 0; k = 0;
        while (req_ack == '0 && k < 100) begin
          tick();
          if (Adder_valid) n++;
          k++;
        end
        chk("valid_cycles", 64'(n), 64'(3));
      end
    join
    repeat (2) tick();

    // Carry-out returned on requester 1 only.
    run_req(1, 25'h1FFFFFF, 25'h0000001);
    repeat (2) tick();

    // Withdrawal of requester 1 while requester 0 is busy.
    cfg_lat = 4;
    s = grant_log.size();
    fork
      run_req(0, rnd_op(), rnd_op());
      begin
        tick(); tick();
        op1[1] = rnd_op(); op2[1] = rnd_op(); rv[1] = 1'b1;
        tick();
        rv[1] = 1'b0;
      end
    join
    repeat (3) tick();
    chk("withdraw_grants", 64'(grant_log.size() - s), 64'(1));

    // Slow adder release with requester 1 pending.
    cfg_lat = 1; cfg_hold = 3;
    fork
      run_req(0, rnd_op(), rnd_op());
      begin tick(); tick(); run_req(1, rnd_op(), rnd_op()); end
      begin
        k = 0;
        while (!req_ack[0] && k < 100) begin tick(); k++; end
        tick();
        n = 0;
        while (a_ack && k < 100) begin
          chk("slow_busy", 64'(busy), 64'(1));
          chk("slow_no_valid", 64'(Adder_valid), 64'(0));
          chk("slow_grant", 64'(grant), 64'(onehot(0)));
          n++; tick(); k++;
        end
        chk("slow_hold_seen", 64'(n > 0), 64'(1));
      end
    join
    cfg_hold = 0; cfg_lat = 2;
    repeat (2) tick();

    // Contention from reset: strict alternation starting at requester 1.
    RSTK = 1'b0;
    tick();
    s = grant_log.size();
    fork
      begin repeat (2) run_req(0, rnd_op(), rnd_op()); end
      begin repeat (2) run_req(1, rnd_op(), rnd_op()); end
      begin tick(); RSTK = 1'b1; end
    join
    chk("contention_count", 64'(grant_log.size() - s), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (s + i < grant_log.size())
        chk("contention_order", 64'(grant_log[s + i]), 64'(onehot((i + 1) % 2)));
    end
    repeat (2) tick();

    // Reset in the middle of a transaction.
    cfg_lat = 10;
    op1[0] = rnd_op(); op2[0] = rnd_op(); rv[0] = 1'b1;
    k = 0;
    while (!Adder_valid && k < 50) begin tick(); k++; end
    chk("midrst_started", 64'(Adder_valid), 64'(1));
    RSTK = 1'b0;
    tick();
    chk("midrst_adder_valid", 64'(Adder_valid), 64'(0));
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    rv[0] = 1'b0;
    RSTK = 1'b1;
    cfg_lat = 2;
    repeat (2) tick();

    // Randomized concurrent traffic.
    cfg_rand = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      automatic int id = i;
      fork
        rand_req(id);
      join_none
    end
    wait fork;
    repeat (5) tick();
    chk("scoreboard_empty", 64'(exp_id.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
